// File: rtl/ram_fifo_ctrl.sv
// Valid/ready queue built on an external 256x16 single-port RAM with async read.
// One registered output word plus the RAM gives DEPTH+1 entries of storage.
module ram_fifo_ctrl #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = (1 << AW)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW+1:0] level,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_wd,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rd
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_ram_cnt;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;

  logic w_drain;
  logic w_rd_go;
  logic w_bypass;
  logic w_in_ready;
  logic w_wr_go;
  logic w_ram_wr;

  // The output register frees up when empty or consumed; the RAM refills it first.
  assign w_drain    = ~r_out_valid | out_ready;
  assign w_rd_go    = w_drain & (r_ram_cnt != '0);
  assign w_bypass   = w_drain & (r_ram_cnt == '0);
  // Reads own the single RAM port, so writes yield whenever a read is due.
  assign w_in_ready = rstn & ~w_rd_go & (w_bypass | (r_ram_cnt < L_DEPTH));
  assign w_wr_go    = in_valid & w_in_ready;
  assign w_ram_wr   = w_wr_go & ~w_bypass;

  assign in_ready  = w_in_ready;
  assign ram_a     = w_rd_go ? r_rd_ptr : r_wr_ptr;
  assign ram_wd    = in_data;
  assign ram_we    = w_ram_wr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign level     = {1'b0, r_ram_cnt} + (AW+2)'(r_out_valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_rd_go) begin
        r_out_data  <= ram_rd;
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + 1'b1;
      end else if (w_wr_go && w_bypass) begin
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end

      if (w_ram_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      // A read and a RAM write never happen in the same cycle.
      if (w_rd_go) begin
        r_ram_cnt <= r_ram_cnt - 1'b1;
      end else if (w_ram_wr) begin
        r_ram_cnt <= r_ram_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 256x16 async-read RAM attached.
module tb_ram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic [15:0] in_data = 16'd10;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [9:0]  level;
  logic [7:0]  ram_a;
  logic [15:0] ram_wd;
  logic        ram_we;
  logic [15:0] ram_rd;

  logic [15:0] mem [256];
  logic [15:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int wrap_cnt = 0;
  int last_wa = -1;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_a(ram_a), .ram_wd(ram_wd), .ram_we(ram_we), .ram_rd(ram_rd)
  );

  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_wd;
  assign ram_rd = mem[ram_a];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Output side: head must match the oldest accepted word; occupancy must match the model.
  always @(negedge clk) begin
    #1;
    chk("level", 32'(level), 32'(exp_q.size()));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_empty: got %0d want none", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Input side: every accepted word is expected later, in order.
  always @(negedge clk) begin
    #2;
    if (in_valid && in_ready) exp_q.push_back(in_data);
    if (ram_we) begin
      if (ram_a == 8'd0 && last_wa == 255) wrap_cnt++;
      last_wa = int'(ram_a);
    end
  end

  task automatic push_word(input logic [15:0] d, output logic [7:0] a);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #3;
    while (!in_ready && n < 2000) begin @(negedge clk); #3; n++; end
    a = ram_a;
    chk("push_timeout", 32'(n < 2000), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    while (level != 10'd0 && n < 2000) begin @(negedge clk); #3; n++; end
    chk("drain_timeout", 32'(n < 2000), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, a0;
    int n, cnt, sent, wraps0;
    logic [15:0] seq;

    // 1: reset state, then bypass of the first word and RAM write of the second
    @(negedge clk); #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    in_data = 16'd40;
    #3;
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_data", 32'(out_data), 10);
    chk("t1_ram_we", 32'(ram_we), 1);
    chk("t1_ram_a", 32'(ram_a), 0);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    chk("t1_level", 32'(level), 2);
    @(negedge clk);
    drain();

    // 2: fill to DEPTH+1, then stream out one word per cycle
    for (int i = 0; i <= 256; i++) push_word(16'(i), a);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    #3;
    chk("t2_level", 32'(level), 257);
    chk("t2_in_ready", 32'(in_ready), 0);
    chk("t2_ram_we", 32'(ram_we), 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 257; i++) begin
      #3;
      if (out_valid) cnt++;
      @(negedge clk);
    end
    #3;
    chk("t2_stream_cycles", 32'(cnt), 257);
    chk("t2_empty_valid", 32'(out_valid), 0);
    @(negedge clk);
    out_ready = 1'b0;

    // 3: random traffic across the pointer wrap
    wraps0 = wrap_cnt;
    seq  = 16'd1000;
    sent = 0;
    n    = 0;
    while (sent < 600 && n < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = seq;
      out_ready = ($urandom_range(0, 9) < 4);
      #3;
      if (in_valid && in_ready) begin sent++; seq++; end
      @(negedge clk);
      n++;
    end
    chk("t3_sent", 32'(sent), 600);
    drain();
    chk("t3_wrap_seen", 32'(wrap_cnt > wraps0), 1);

    // 4: reads own the port while RAM holds words; bypass once it empties
    push_word(16'h0A01, a);
    push_word(16'h0A02, a0);
    push_word(16'h0A03, a);
    push_word(16'h0A04, a);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h4444;
    #3;
    chk("t4_ram_a", 32'(ram_a), 32'(a0));
    chk("t4_ram_we", 32'(ram_we), 0);
    chk("t4_in_ready", 32'(in_ready), 0);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); #3; n++; end
    chk("t4_stall_cycles", 32'(n), 3);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("t4_bypass_valid", 32'(out_valid), 1);
    chk("t4_bypass_data", 32'(out_data), 32'h4444);
    @(negedge clk);
    drain();

    // 5: idle with out_ready high
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    a = ram_a;
    for (int i = 0; i < 5; i++) begin
      chk("t5_out_valid", 32'(out_valid), 0);
      chk("t5_ram_we", 32'(ram_we), 0);
      chk("t5_level", 32'(level), 0);
      @(negedge clk);
      #3;
    end
    chk("t5_ram_a_still", 32'(ram_a), 32'(a));
    @(negedge clk);
    out_ready = 1'b0;

    // 6: asynchronous reset mid-stream, then a fresh bypass word
    for (int i = 0; i < 50; i++) push_word(16'(16'h0100 + i), a);
    in_valid = 1'b1;
    in_data  = 16'd114;
    #3;
    chk("t6_level_before", 32'(level), 50);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_level", 32'(level), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 0);
    chk("t6_rst_ram_we", 32'(ram_we), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    chk("t6_first_valid", 32'(out_valid), 1);
    chk("t6_first_data", 32'(out_data), 114);
    chk("t6_first_level", 32'(level), 1);
    @(negedge clk);
    drain();
    chk("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
